// File: rtl/lr35902_lbus_pkg.sv
// Shared types and address map for the LR35902 low-address bus controller.
package lr35902_lbus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BROM,
    S_REG,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } lbus_state_e;

  localparam logic [15:0] BROM_END     = 16'h00FF;
  localparam logic [15:0] CROM_END     = 16'h7FFF;
  localparam logic [15:0] CRAM_BASE    = 16'hA000;
  localparam logic [15:0] CRAM_END     = 16'hBFFF;
  localparam logic [15:0] BROM_DIS_ADR = 16'hFF50;

  localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/lr35902_cart_seq.sv
// Cartridge pin sequencer: SETUP -> STROBE (CART_WAIT cycles) -> HOLD, all pins registered.
module lr35902_cart_seq
  import lr35902_lbus_pkg::*;
#(
  parameter int unsigned CART_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        is_write_i,
  input  logic        is_ram_i,
  input  logic [15:0] adr_i,
  input  logic [7:0]  wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        rd_done_o,
  output logic [15:0] cart_adr_o,
  output logic [7:0]  cart_data_out_o,
  output logic        cart_data_oe_o,
  output logic        cart_rd_n_o,
  output logic        cart_wr_n_o,
  output logic        cart_cs_n_o
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CART_WAIT - 1);
  localparam logic [WAIT_W-1:0] CNT_ONE   = WAIT_W'(1);

  lbus_state_e       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [15:0]       adr_q, adr_d;
  logic [7:0]        dout_q, dout_d;
  logic              oe_q, oe_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              cs_n_q, cs_n_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      adr_q   <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      adr_q   <= adr_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      cs_n_q  <= cs_n_d;
    end
  end

  // done_o is combinational in the last STROBE cycle so the parent can register ack into HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    adr_d   = adr_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    rd_n_d  = rd_n_q;
    wr_n_d  = wr_n_q;
    cs_n_d  = cs_n_q;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_SETUP;
          adr_d   = adr_i;
          cs_n_d  = ~is_ram_i;
          wr_d    = is_write_i;
          oe_d    = is_write_i;
          if (is_write_i) dout_d = wdata_i;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = WAIT_LOAD;
        rd_n_d  = wr_q;
        wr_n_d  = ~wr_q;
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          done_o  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        oe_d    = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o          = (state_q != S_IDLE);
  assign rd_done_o       = done_o & ~wr_q;
  assign cart_adr_o      = adr_q;
  assign cart_data_out_o = dout_q;
  assign cart_data_oe_o  = oe_q;
  assign cart_rd_n_o     = rd_n_q;
  assign cart_wr_n_o     = wr_n_q;
  assign cart_cs_n_o     = cs_n_q;

endmodule

// File: rtl/lr35902_lbus_ctrl.sv
// Low-address bus controller: decodes CPU requests to boot ROM, FF50 register or cartridge.
module lr35902_lbus_ctrl
  import lr35902_lbus_pkg::*;
#(
  parameter int unsigned CART_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_adr_i,
  input  logic [7:0]  cpu_dout_i,
  input  logic        cpu_read_i,
  input  logic        cpu_write_i,
  output logic [7:0]  cpu_din_o,
  output logic        cpu_ack_o,
  output logic [7:0]  brom_adr_o,
  output logic        brom_read_o,
  input  logic [7:0]  brom_dout_i,
  input  logic        brom_hide_i,
  output logic        brom_write_reg_o,
  output logic [15:0] cart_adr_o,
  output logic [7:0]  cart_data_out_o,
  input  logic [7:0]  cart_data_in_i,
  output logic        cart_data_oe_o,
  output logic        cart_rd_n_o,
  output logic        cart_wr_n_o,
  output logic        cart_cs_n_o
);

  lbus_state_e state_q, state_d;
  logic [7:0]  din_q, din_d;
  logic        ack_q, ack_d;
  logic        wreg_q, wreg_d;

  logic seq_start, seq_busy, seq_done, seq_rd_done;
  logic is_wr, req, accept, brom_hit, reg_hit, cram_hit, cart_hit;

  // Simultaneous read+write is a write; writes never target the boot ROM.
  assign is_wr    = cpu_write_i;
  assign req      = cpu_read_i | cpu_write_i;
  assign accept   = req && (state_q == S_IDLE) && !seq_busy;
  assign brom_hit = !is_wr && !brom_hide_i && (cpu_adr_i <= BROM_END);
  assign reg_hit  = (cpu_adr_i == BROM_DIS_ADR);
  assign cram_hit = (cpu_adr_i >= CRAM_BASE) && (cpu_adr_i <= CRAM_END);
  assign cart_hit = ((cpu_adr_i <= CROM_END) && !brom_hit) || cram_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      din_q   <= 8'hFF;
      ack_q   <= 1'b0;
      wreg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      wreg_q  <= wreg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    din_d       = din_q;
    ack_d       = 1'b0;
    wreg_d      = 1'b0;
    seq_start   = 1'b0;
    brom_read_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (brom_hit) begin
            brom_read_o = 1'b1;
            state_d     = S_BROM;
          end else if (reg_hit) begin
            state_d = S_REG;
            ack_d   = 1'b1;
            wreg_d  = is_wr;
            if (!is_wr) din_d = 8'hFF;
          end else if (cart_hit) begin
            seq_start = 1'b1;
          end
        end
      end
      S_BROM: begin
        state_d = S_IDLE;
        ack_d   = 1'b1;
        din_d   = brom_dout_i;
      end
      S_REG:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (seq_done) ack_d = 1'b1;
    if (seq_rd_done) din_d = cart_data_in_i;
  end

  lr35902_cart_seq #(
    .CART_WAIT(CART_WAIT)
  ) u_cart_seq (
    .clk            (clk),
    .reset          (reset),
    .start_i        (seq_start),
    .is_write_i     (is_wr),
    .is_ram_i       (cram_hit),
    .adr_i          (cpu_adr_i),
    .wdata_i        (cpu_dout_i),
    .busy_o         (seq_busy),
    .done_o         (seq_done),
    .rd_done_o      (seq_rd_done),
    .cart_adr_o     (cart_adr_o),
    .cart_data_out_o(cart_data_out_o),
    .cart_data_oe_o (cart_data_oe_o),
    .cart_rd_n_o    (cart_rd_n_o),
    .cart_wr_n_o    (cart_wr_n_o),
    .cart_cs_n_o    (cart_cs_n_o)
  );

  assign cpu_din_o        = din_q;
  assign cpu_ack_o        = ack_q;
  assign brom_adr_o       = cpu_adr_i[7:0];
  assign brom_write_reg_o = wreg_q;

endmodule

// File: doc/lr35902_lbus_ctrl.md
Name: lr35902_lbus_ctrl

Overview:
Low-address bus controller between the LR35902 core's memory port and two targets: the boot ROM and the external cartridge bus.
- Decodes each CPU request to one of: boot ROM (0x0000-0x00FF while not hidden), cartridge ROM (0x0000-0x7FFF), cartridge RAM (0xA000-0xBFFF) or the boot-ROM disable register (0xFF50).
- Drives the boot ROM's one-cycle registered read and converts the 1-cycle request strobe into a multi-cycle cartridge pin sequence.
- Returns read data with a single-cycle acknowledge.

Parameters:
CART_WAIT, 2, number of cycles the cartridge rd_n/wr_n strobe stays low; legal range 1..15.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cpu_adr  in  16  request address, valid in the strobe cycle
cpu_dout  in  8  write data from CPU, valid in the strobe cycle
cpu_read  in  1  1-cycle read request strobe
cpu_write  in  1  1-cycle write request strobe
cpu_din  out  8  read data to CPU, valid while cpu_ack=1
cpu_ack  out  1  1-cycle completion pulse
brom_adr  out  8  boot ROM address
brom_read  out  1  boot ROM read enable
brom_dout  in  8  boot ROM registered data
brom_hide  in  1  boot ROM disabled flag
brom_write_reg  out  1  1-cycle pulse that hides the boot ROM
cart_adr  out  16  cartridge address pins
cart_data_out  out  8  cartridge write data
cart_data_in  in  8  cartridge read data
cart_data_oe  out  1  drive enable for cart_data_out
cart_rd_n  out  1  cartridge read strobe, active low
cart_wr_n  out  1  cartridge write strobe, active low
cart_cs_n  out  1  cartridge RAM select, active low; asserted for 0xA000-0xBFFF only

Behaviour:
Reset values:
- cpu_din=0xFF, cpu_ack=0, brom_read=0, brom_write_reg=0.
- cart_adr=0, cart_data_out=0, cart_data_oe=0, cart_rd_n=1, cart_wr_n=1, cart_cs_n=1.
- FSM returns to IDLE.

Reset mid-operation:
- Aborts the access immediately.
- No ack is ever produced for the aborted request.
- All pins return to idle values on the next edge.

Request acceptance:
- A request is accepted only in IDLE.
- Strobes arriving in any other state are ignored: no ack, no side effects.
- cpu_read and cpu_write asserted together are treated as a write.
- Addresses outside the four decoded ranges are ignored: no ack, no pin activity. Other bus slaves own those ranges.

Boot ROM read (cpu_read, adr<0x0100, brom_hide=0):
- brom_adr=cpu_adr[7:0] and brom_read=1 are driven combinationally in the strobe cycle.
- FSM moves to BROM.
- At the next edge cpu_din<=brom_dout and cpu_ack pulses.
- Ack therefore appears in the second cycle after the strobe.
- Writes to 0x0000-0x00FF always go to the cartridge, regardless of brom_hide.

FF50:
- Write: brom_write_reg pulses for 1 cycle, registered and starting the cycle after the strobe; cpu_ack pulses in the same cycle. Any data value triggers the pulse.
- Read: cpu_din=0xFF with ack the cycle after the strobe.

Cartridge access (ROM range with hidden/out-of-range boot ROM, or RAM range). States run IDLE -> SETUP -> STROBE -> HOLD -> IDLE:
- SETUP (1 cycle): cart_adr is latched; cart_cs_n=0 for the RAM range; for writes, cart_data_out<=cpu_dout and cart_data_oe=1.
- STROBE (CART_WAIT cycles, 4-bit down-counter): rd_n=0 for reads, wr_n=0 for writes.
- Read data: cart_data_in is sampled into cpu_din on the edge that ends the last STROBE cycle.
- HOLD (1 cycle): strobes=1; address, cs_n and oe are still held; cpu_ack=1 in this cycle.
- Return to IDLE: cs_n=1 and oe=0. cart_adr keeps its last value.
- Total strobe-to-ack latency is CART_WAIT+2 cycles.
- A new request is accepted in the IDLE cycle following HOLD.

Other rules:
- All outputs except brom_adr and brom_read are registered.
- cpu_din holds its last value outside ack cycles.

Decomposition:
Shared package lr35902_lbus_pkg holds:
- the FSM state enum (IDLE, BROM, REG, SETUP, STROBE, HOLD);
- address constants BROM_END=0x00FF, CROM_END=0x7FFF, CRAM_BASE=0xA000, CRAM_END=0xBFFF, BROM_DIS_ADR=0xFF50;
- the wait-counter width.

The cartridge pin sequencer (SETUP/STROBE/HOLD plus the counter) is a natural sub-module, lr35902_cart_seq, with a start/is_write/done interface.

Test Plan:
1. brom_hide=0, brom_dout=0x31, read 0x0000 -> brom_read=1 with brom_adr=0x00 in the strobe cycle; cpu_ack and cpu_din=0x31 two cycles later; cart_rd_n stays 1.
2. Write 0x01 to 0xFF50 -> brom_write_reg high exactly 1 cycle and ack the cycle after the strobe. Then, with brom_hide=1, read 0x0000 -> cart_rd_n low 2 cycles, ack at cycle 4, cpu_din equals cart_data_in.
3. CART_WAIT=3, write 0x5A to 0xA123 -> cs_n=0 and oe=1 from SETUP through HOLD; wr_n low exactly 3 cycles; cart_data_out=0x5A; ack at cycle 5; cs_n=1 afterwards.
4. Read 0x8000 or 0xC000 -> no ack, all cart pins idle. A second strobe issued during STROBE -> ignored, exactly one ack.
5. Assert reset during STROBE of a read -> rd_n=1 on the next edge, no ack; the next read of 0x4000 completes normally.
6. cpu_read and cpu_write together at 0x2000 with data 0x03 -> wr_n sequence only; rd_n never low.
